// File: rtl/alu_result_tx.sv
// -----------------------------------------------------------------------------
// alu_result_tx
//
// Queues registered ALU result bytes in a small FIFO and streams them out as
// UART frames: one start bit (low), 8 data bits LSB first, an optional even
// parity bit, and one stop bit (high).  Consecutive queued words are sent
// back to back with no idle gap between frames.
//
// Build option:
//   ALU_TX_PARITY_EN  - when defined, an even-parity bit (XOR of the 8 data
//                       bits) is inserted between the last data bit and the
//                       stop bit.  When undefined, no parity state or logic
//                       exists and STOP follows data bit 7.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (2..1023)
//   FIFO_DEPTH   - result FIFO entries, power of two (2..16)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   res_in     in   [7:0] ALU result word
//   res_valid  in   res_in carries a new result this cycle
//   res_ready  out  FIFO not full; a push is accepted this cycle
//   tx         out  UART serial line, idle high (registered)
//   busy       out  a frame is in progress
//   fifo_count out  number of entries stored
//   overflow   out  sticky: a valid result was dropped because FIFO was full
// -----------------------------------------------------------------------------
module alu_result_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    res_in,
  input  logic                          res_valid,
  output logic                          res_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [FC_W-1:0]  FULL_COUNT = FC_W'(FIFO_DEPTH);
  localparam logic [FC_W-1:0]  FC_ZERO    = FC_W'(0);
  localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef ALU_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

`ifdef ALU_TX_PARITY_EN
  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FC_W-1:0]  count;
  logic             overflow_r;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // ---------------------------------------------------------------------------
  // Transmitter state
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic             tx_r;
  logic             tx_next;
  logic             bit_end;
`ifdef ALU_TX_PARITY_EN
  logic             parity_r;
  logic             parity_next;
`endif

  // Ready depends only on stored state; a pop in the same cycle does not
  // free a slot for the incoming word.
  assign res_ready  = (count != FULL_COUNT);
  assign push       = res_valid & res_ready;
  assign head       = mem[rd_ptr];
  assign bit_end    = (bit_cnt == BIT_LAST);

  assign tx         = tx_r;
  assign busy       = (state != IDLE);
  assign fifo_count = count;
  assign overflow   = overflow_r;

  // FIFO data array; contents are only read when count is nonzero, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= PTR_ZERO;
      rd_ptr     <= PTR_ZERO;
      count      <= FC_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + FC_ONE;
        2'b01:   count <= count - FC_ONE;
        default: count <= count;
      endcase
      if (res_valid && !res_ready) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Transmitter state register, including the registered serial output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= CNT_ZERO;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      tx_r      <= 1'b1;
`ifdef ALU_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      tx_r      <= tx_next;
`ifdef ALU_TX_PARITY_EN
      parity_r  <= parity_next;
`endif
    end
  end

  // Next-state logic: bit timing, data shifting and FIFO pops.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    pop          = 1'b0;
`ifdef ALU_TX_PARITY_EN
    parity_next  = parity_r;
`endif

    case (state)
      IDLE: begin
        if (count != FC_ZERO) begin
          pop          = 1'b1;
          shift_next   = head;
`ifdef ALU_TX_PARITY_EN
          parity_next  = even_parity(head);
`endif
          bit_cnt_next = CNT_ZERO;
          bit_idx_next = 3'd0;
          state_next   = START;
        end else begin
          bit_cnt_next = CNT_ZERO;
        end
      end

      START: begin
        if (bit_end) begin
          bit_cnt_next = CNT_ZERO;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (bit_end) begin
          bit_cnt_next = CNT_ZERO;
          shift_next   = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_next = 3'd0;
`ifdef ALU_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

`ifdef ALU_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          bit_cnt_next = CNT_ZERO;
          state_next   = STOP;
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          bit_cnt_next = CNT_ZERO;
          // Chain straight into the next frame when more data is queued.
          if (count != FC_ZERO) begin
            pop          = 1'b1;
            shift_next   = head;
`ifdef ALU_TX_PARITY_EN
            parity_next  = even_parity(head);
`endif
            bit_idx_next = 3'd0;
            state_next   = START;
          end else begin
            state_next   = IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = CNT_ZERO;
        bit_idx_next = 3'd0;
      end
    endcase
  end

  // Serial output for the coming cycle, derived from the next state so the
  // line changes on the same edge as the state it represents.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef ALU_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// -----------------------------------------------------------------------------
// tb_alu_result_tx
//
// Directed bench for alu_result_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, so a sample taken after edge e shows the effect of e.
// Define ALU_TX_PARITY_EN for both RTL and bench to exercise the parity build.
// -----------------------------------------------------------------------------
module tb_alu_result_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] res_in;
  logic       res_valid;
  logic       res_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_in    (res_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle i of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
`ifdef ALU_TX_PARITY_EN
    else if (b == 9) return ^d;
`endif
    else return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_in    = 8'h00;
    tick();
    tick();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", res_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [7:0] d);
    res_in    = d;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    res_in    = 8'h00;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_push: got %0d want 1", fifo_count); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_push_edge: got %b want 1", tx); end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_checks++;
      if (tx !== exp_bit(d, i)) begin
        n_fail++; $display("FAIL single_tx[%0d] data %h: got %b want %b", i, d, tx, exp_bit(d, i));
      end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %b want 1", i, busy); end
`ifdef ALU_TX_PARITY_EN
      if (i == 37) begin
        n_checks++;
        if (tx !== ^d) begin n_fail++; $display("FAIL parity_bit data %h: got %b want %b", d, tx, ^d); end
      end
`endif
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_end: got %b want 1", tx); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_end: got %0d want 0", fifo_count); end
  endtask

  // Six consecutive valid words into an idle block: first popped on the
  // second edge, FIFO fills, sixth is dropped, five frames back to back.
  task automatic test_burst;
    int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
    int n;
    logic [7:0] w;
    n = 0;
    for (int c = 1; c <= 6; c++) begin
      res_in    = 8'(c);
      res_valid = 1'b1;
      tick();
      n_checks++;
      if (fifo_count !== 3'(exp_cnt[c-1])) begin
        n_fail++; $display("FAIL burst_count[%0d]: got %0d want %0d", c, fifo_count, exp_cnt[c-1]);
      end
      n_checks++;
      if (res_ready !== (c < 5)) begin
        n_fail++; $display("FAIL burst_ready[%0d]: got %b want %b", c, res_ready, (c < 5));
      end
      n_checks++;
      if (overflow !== (c == 6)) begin
        n_fail++; $display("FAIL burst_overflow[%0d]: got %b want %b", c, overflow, (c == 6));
      end
      if (c >= 2) begin
        n_checks++;
        if (tx !== exp_bit(8'h01, n)) begin
          n_fail++; $display("FAIL burst_tx[%0d]: got %b want %b", n, tx, exp_bit(8'h01, n));
        end
        n++;
      end
    end
    res_valid = 1'b0;
    res_in    = 8'h00;
    while (n < 5 * FRAME) begin
      tick();
      w = 8'(n / FRAME + 1);
      n_checks++;
      if (tx !== exp_bit(w, n % FRAME) || busy !== 1'b1) begin
        n_fail++; $display("FAIL burst_tx[%0d]: tx %b busy %b want tx %b busy 1", n, tx, busy, exp_bit(w, n % FRAME));
      end
      n++;
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL burst_count_end: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_overflow_sticky: got %b want 1", overflow); end
  endtask

  // Reset pulse mid-frame with two words queued (overflow still set from
  // the burst): everything clears and no further frames appear.
  task automatic test_reset_mid;
    res_in    = 8'h11;
    res_valid = 1'b1;
    tick();
    for (int n = 0; n < 15; n++) begin
      res_valid = (n < 2);
      res_in    = (n == 0) ? 8'h22 : ((n == 1) ? 8'h33 : 8'h00);
      tick();
      n_checks++;
      if (tx !== exp_bit(8'h11, n)) begin
        n_fail++; $display("FAIL rstmid_tx[%0d]: got %b want %b", n, tx, exp_bit(8'h11, n));
      end
    end
    res_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL rstmid_count_before: got %0d want 2", fifo_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
        n_fail++; $display("FAIL rstmid_quiet[%0d]: tx %b busy %b count %0d want 1 0 0", i, tx, busy, fifo_count);
      end
    end
  endtask

  // Push coinciding with the STOP-end pop keeps the count at 1 and the
  // next frame starts with no gap; idle res_in garbage is ignored.
  task automatic test_back_to_back;
    logic [7:0] words [3] = '{8'h3C, 8'h5A, 8'hC3};
    logic [7:0] w;
    res_in    = words[0];
    res_valid = 1'b1;
    tick();
    for (int n = 0; n < 3 * FRAME; n++) begin
      res_valid = (n == 5) || (n == FRAME);
      res_in    = (n == 5) ? words[1] : ((n == FRAME) ? words[2] : 8'hEE);
      tick();
      res_valid = 1'b0;
      w = words[n / FRAME];
      n_checks++;
      if (tx !== exp_bit(w, n % FRAME)) begin
        n_fail++; $display("FAIL b2b_tx[%0d]: got %b want %b", n, tx, exp_bit(w, n % FRAME));
      end
      if (n == 5 || n == FRAME) begin
        n_checks++;
        if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 1", n, fifo_count); end
      end
      if (n == 20) begin
        n_checks++;
        if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count_ignored: got %0d want 1", fifo_count); end
      end
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_count_end: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_in    = 8'h00;
    test_reset();
    test_single(8'hA5);
    test_burst();
    test_reset_mid();
    test_back_to_back();
`ifdef ALU_TX_PARITY_EN
    test_single(8'h07);
    test_single(8'h03);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_tx.md
ALU_RESULT_TX -- requirements
Module: alu_result_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..1023.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries, fixed power of two, legal 2..16.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port res_in  input  8  registered ALU result word.
REQ-006 SHALL have port res_valid  input  1  res_in holds a new result this cycle.
REQ-007 SHALL have port res_ready  output  1  FIFO not full; push accepted this cycle.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-010 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  entries currently stored.
REQ-011 SHALL have port overflow  output  1  sticky: a valid result was dropped.

Function
REQ-012 SHALL push res_in on an edge where res_valid=1 and res_ready=1; res_ready SHALL be registered-state based (count != FIFO_DEPTH), no same-cycle pop bypass.
REQ-013 SHALL drop res_in and set overflow=1 on an edge where res_valid=1 and res_ready=0; overflow clears only on reset.
REQ-014 SHALL, on simultaneous push and pop, perform both; fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (only when enabled), STOP.
REQ-016 IDLE: on edge with fifo_count>0, SHALL pop head into shift register and enter START; tx low from that edge.
REQ-017 Each of START, each DATA bit, PARITY, STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter.
REQ-018 DATA SHALL send 8 bits LSB first; bit index counter 0..7 then advance.
REQ-019 STOP: tx high; at end, SHALL pop and go directly to START if fifo_count>0 (no idle gap), else IDLE.
REQ-020 Frame SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-021 Latency: word pushed at edge k with FIFO empty and FSM IDLE SHALL drive start bit from edge k+1.
REQ-022 SHALL ignore res_in when res_valid=0; no X propagation to tx.

Reset
REQ-023 On rst_n=0 at an edge: tx=1, busy=0, fifo_count=0, overflow=0, res_ready=1, FSM=IDLE, counters=0.
REQ-024 Reset mid-frame SHALL abort frame and discard all FIFO contents; tx high from the following edge.

Configuration
REQ-025 Macro ALU_TX_PARITY_EN defined: SHALL insert one even-parity bit (XOR of 8 data bits) between DATA and STOP.
REQ-026 Macro ALU_TX_PARITY_EN undefined: PARITY state and logic SHALL be absent; STOP follows DATA bit 7.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Single push 0xA5 into idle block -> tx: 4 low, then 1,0,1,0,0,1,0,1 (4 cycles each), 4 high; busy high 40 cycles; fifo_count back to 0.
REQ-028 res_valid held 6 consecutive cycles, words 0x01..0x06, FSM idle -> 0x01 popped at 2nd edge, count reaches 4, res_ready low, 0x06 dropped, overflow=1; tx emits 0x01..0x05 back-to-back, 200 cycles, no gap.
REQ-029 Push during active frame with count=1 coinciding with STOP-end pop -> count stays 1, next frame starts without gap.
REQ-030 rst_n low for 1 cycle at cycle 15 of frame with 2 queued -> tx=1, busy=0, fifo_count=0, overflow=0; no further frames.
REQ-031 With ALU_TX_PARITY_EN, push 0x07 -> parity bit 1, frame 44 cycles; push 0x03 -> parity bit 0.
